fpu_result_collector: RTL and testbench

Completion side of the FPU enable path. The enable decoder raises a one-hot `unit_enable` to launch one of the 12 arithmetic units. This block latches which unit was launched and waits for that unit's done strobe. It then captures the unit's result and presents it to the register interface with a sticky done flag, a one-cycle interrupt pulse, the encoded `{operation, format}` code and error flags, and holds them until software acknowledges.

---
 rtl/fpu_result_collector_if.sv | 27 ++
 rtl/fpu_result_collector.sv | 180 ++++++++++++++++++
 tb/tb_fpu_result_collector.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_result_collector_if.sv
// Handshake bundle between the FPU enable path, the arithmetic units and the
// register interface. The collector connects through the slave modport; the
// side that launches units and acknowledges status uses the master modport.
interface fpu_result_collector_if #(
  parameter int DATA_W = 32
);
  logic [11:0]          unit_enable;
  logic [11:0]          unit_done;
  logic [12*DATA_W-1:0] unit_result;
  logic                 fpu_status_ack;
  logic                 fpu_busy;
  logic                 fpu_done;
  logic                 fpu_irq;
  logic [DATA_W-1:0]    fpu_result;
  logic [3:0]           fpu_op_code;
  logic [3:0]           fpu_err;

  modport master (
    output unit_enable, unit_done, unit_result, fpu_status_ack,
    input  fpu_busy, fpu_done, fpu_irq, fpu_result, fpu_op_code, fpu_err
  );

  modport slave (
    input  unit_enable, unit_done, unit_result, fpu_status_ack,
    output fpu_busy, fpu_done, fpu_irq, fpu_result, fpu_op_code, fpu_err
  );
endinterface

// File: rtl/fpu_result_collector.sv
// Completion collector for the FPU enable path: remembers which unit was
// launched, waits for its done strobe, captures its result and holds status
// until software acknowledges.
// Optional feature macro: FPU_COLLECTOR_TIMEOUT_EN builds the WAIT timeout
// timer and err[3]; without it WAIT lasts until the expected done or a reset.
//
// state | meaning
// IDLE  | no operation outstanding, accepting a one-hot launch
// WAIT  | launched unit running, waiting for its done strobe (busy)
// DONE  | result/op code/errors held, waiting for software ack
module fpu_result_collector #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  rst,
  fpu_result_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t              state_q, state_d;
  logic [11:0]         mask_q, mask_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          err_q, err_d;
  logic                irq_q, irq_d;

`ifdef FPU_COLLECTOR_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  // Down-counter: loaded on launch, timeout declared at terminal count zero.
  logic [TIMER_W-1:0]  timer_q, timer_d;
`endif

  logic [11:0]         en, dn, hit;
  logic                en_soft, en_one_hot, en_cmd;
  logic [3:0]          launch_code;
  logic [DATA_W-1:0]   hit_data;

  assign en         = bus.unit_enable;
  assign dn         = bus.unit_done;
  assign hit        = dn & mask_q;
  assign en_soft    = (en == 12'hFFF);
  assign en_one_hot = (en != 12'd0) && ((en & (en - 12'd1)) == 12'd0);
  assign en_cmd     = (en != 12'd0) && !en_soft;

  // Encode the launched bit i as {k/3, k%3} with k = 11 - i.
  always_comb begin
    launch_code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (en[i]) launch_code = {2'((11 - i) / 3), 2'((11 - i) % 3)};
    end
  end

  // Select the result lane of the expected unit.
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < 12; i++) begin
      if (hit[i]) hit_data = bus.unit_result[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic; soft reset overrides every event.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    irq_d    = 1'b0;
`ifdef FPU_COLLECTOR_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    if (en_soft) begin
      state_d  = IDLE;
      mask_d   = '0;
      op_d     = '0;
      result_d = '0;
      err_d    = '0;
`ifdef FPU_COLLECTOR_TIMEOUT_EN
      timer_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (en_one_hot) begin
            mask_d  = en;
            op_d    = launch_code;
            state_d = WAIT;
`ifdef FPU_COLLECTOR_TIMEOUT_EN
            timer_d = TIMER_LOAD;
`endif
          end else if (en_cmd) begin
            err_d[0] = 1'b1;
          end
          if (dn != 12'd0) err_d[1] = 1'b1;
        end
        WAIT: begin
          if (hit != 12'd0) begin
            result_d = hit_data;
            irq_d    = 1'b1;
            state_d  = DONE;
          end
`ifdef FPU_COLLECTOR_TIMEOUT_EN
          else if (timer_q == '0) begin
            err_d[3] = 1'b1;
            result_d = '0;
            irq_d    = 1'b1;
            state_d  = DONE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
`endif
          if ((dn & ~mask_q) != 12'd0) err_d[1] = 1'b1;
          if (en_cmd) err_d[2] = 1'b1;
        end
        DONE: begin
          if (bus.fpu_status_ack) begin
            state_d  = IDLE;
            mask_d   = '0;
            op_d     = '0;
            result_d = '0;
            err_d    = '0;
            // A launch coinciding with the ack starts the next op immediately.
            if (en_one_hot) begin
              mask_d  = en;
              op_d    = launch_code;
              state_d = WAIT;
`ifdef FPU_COLLECTOR_TIMEOUT_EN
              timer_d = TIMER_LOAD;
`endif
            end
          end else begin
            if (en_cmd) err_d[2] = 1'b1;
            if (dn != 12'd0) err_d[1] = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= '0;
      irq_q    <= 1'b0;
`ifdef FPU_COLLECTOR_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
`ifdef FPU_COLLECTOR_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign bus.fpu_busy    = (state_q == WAIT);
  assign bus.fpu_done    = (state_q == DONE);
  assign bus.fpu_irq     = irq_q;
  assign bus.fpu_result  = result_q;
  assign bus.fpu_op_code = op_q;
  assign bus.fpu_err     = err_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Scoreboard bench for fpu_result_collector: stimulus pushes the expected
// completion record, a negedge monitor pops it whenever fpu_irq fires.
module tb_fpu_result_collector;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_result_collector_if #(.DATA_W(DW)) bus ();

  fpu_result_collector #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] result;
    logic [3:0]    op;
    logic [3:0]    err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  exp_err = 4'd0;
  logic [3:0]  exp_op  = 4'd0;
  logic        irq_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference op code: k = 11 - bit, {k/3, k%3}.
  function automatic logic [3:0] code_of(input int i);
    int k;
    k = 11 - i;
    return 4'((k / 3) * 4 + (k % 3));
  endfunction

  // Monitor: every irq must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (irq_prev) check("irq_one_cycle", bus.fpu_irq, 0);
      if (bus.fpu_irq) begin
        if (sb.size() == 0) check("irq_unexpected", bus.fpu_irq, 0);
        else begin
          e = sb.pop_front();
          check("sb_result", bus.fpu_result, e.result);
          check("sb_op", bus.fpu_op_code, e.op);
          check("sb_err", bus.fpu_err, e.err);
          check("sb_done", bus.fpu_done, 1);
          check("sb_busy", bus.fpu_busy, 0);
        end
      end
      irq_prev = bus.fpu_irq;
    end else begin
      irq_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.unit_enable    = 12'd0;
    bus.unit_done      = 12'd0;
    bus.fpu_status_ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.fpu_busy, 0);
    check({tag, "_done"}, bus.fpu_done, 0);
    check({tag, "_irq"}, bus.fpu_irq, 0);
    check({tag, "_result"}, bus.fpu_result, 0);
    check({tag, "_op"}, bus.fpu_op_code, 0);
    check({tag, "_err"}, bus.fpu_err, 0);
  endtask

  task automatic launch(input int i);
    bus.unit_enable = 12'd1 << i;
    exp_op = code_of(i);
    tick();
    bus.unit_enable = 12'd0;
  endtask

  // Drive the expected done for unit i, optionally with spurious done bits
  // and an overrun enable in the same cycle.
  task automatic finish_op(input int i, input logic [DW-1:0] data,
                           input logic [11:0] extra, input logic [11:0] en_x);
    exp_t e;
    for (int l = 0; l < 12; l++) bus.unit_result[l*DW +: DW] = $urandom;
    bus.unit_result[i*DW +: DW] = data;
    if (extra != 12'd0) exp_err[1] = 1'b1;
    if (en_x != 12'd0) exp_err[2] = 1'b1;
    e.result = data; e.op = exp_op; e.err = exp_err;
    sb.push_back(e);
    bus.unit_done   = (12'd1 << i) | extra;
    bus.unit_enable = en_x;
    tick();
    idle_inputs();
  endtask

  task automatic ack_and_check(input string tag);
    bus.fpu_status_ack = 1'b1;
    tick();
    bus.fpu_status_ack = 1'b0;
    exp_err = 4'd0;
    check_zero(tag);
  endtask

  initial begin
    int i, d, cnt;
    logic [11:0] extra, en_x;
    exp_t e;
    idle_inputs();
    bus.unit_result = '0;
    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Normal completion, done five cycles after the launch.
    launch(11);
    check("t1_busy", bus.fpu_busy, 1);
    repeat (4) tick();
    finish_op(11, 32'h3F80_0000, 12'd0, 12'd0);
    check("t1_irq", bus.fpu_irq, 1);
    check("t1_op", bus.fpu_op_code, 4'b0000);
    tick();
    check("t1_irq_low", bus.fpu_irq, 0);
    check("t1_done_sticky", bus.fpu_done, 1);
    check("t1_result_held", bus.fpu_result, 32'h3F80_0000);
    ack_and_check("t1_ack");

    // Lane 0 mapping, done at the first edge after the launch.
    launch(0);
    finish_op(0, 32'hC0DE_0001, 12'd0, 12'd0);
    check("t2_op", bus.fpu_op_code, 4'b1110);
    ack_and_check("t2_ack");

    // Spurious done plus overrun in the completion cycle.
    launch(7);
    tick();
    finish_op(7, 32'h1234_5678, 12'h001, 12'h004);
    check("t3_err", bus.fpu_err, 4'b0110);
    check("t3_op", bus.fpu_op_code, 4'b0101);
    ack_and_check("t3_ack");

    // Expected done on the last possible WAIT cycle still captures normally.
    launch(3);
    repeat (TO - 1) tick();
    finish_op(3, 32'hABCD_0003, 12'd0, 12'd0);
    check("boundary_done", bus.fpu_done, 1);
    check("boundary_err", bus.fpu_err, 0);
    ack_and_check("boundary_ack");

`ifdef FPU_COLLECTOR_TIMEOUT_EN
    launch(2);
    e.result = '0; e.op = code_of(2); e.err = 4'b1000;
    sb.push_back(e);
    cnt = 0;
    while (!bus.fpu_done && cnt < 40) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, TO);
    check("timeout_err", bus.fpu_err, 4'b1000);
    check("timeout_result", bus.fpu_result, 0);
    ack_and_check("timeout_ack");
`else
    launch(2);
    repeat (100) tick();
    check("no_timeout_busy", bus.fpu_busy, 1);
    check("no_timeout_err", bus.fpu_err, 0);
    bus.unit_enable = 12'hFFF;
    tick();
    bus.unit_enable = 12'd0;
    check_zero("no_timeout_soft");
`endif

    // Bad command in IDLE, then soft reset in the middle of WAIT.
    bus.unit_enable = 12'h003;
    tick();
    bus.unit_enable = 12'd0;
    check("t5_err0", bus.fpu_err, 4'b0001);
    check("t5_idle_busy", bus.fpu_busy, 0);
    check("t5_idle_done", bus.fpu_done, 0);
    launch(9);
    tick();
    check("t5_err_sticky", bus.fpu_err, 4'b0001);
    bus.unit_enable = 12'hFFF;
    tick();
    bus.unit_enable = 12'd0;
    exp_err = 4'd0;
    check_zero("t5_soft");

    // Ack and launch together.
    launch(10);
    finish_op(10, 32'h0000_00AA, 12'h100, 12'd0);
    bus.fpu_status_ack = 1'b1;
    bus.unit_enable    = 12'h020;
    exp_op  = code_of(5);
    exp_err = 4'd0;
    tick();
    idle_inputs();
    check("t6_busy", bus.fpu_busy, 1);
    check("t6_op", bus.fpu_op_code, 4'b1000);
    check("t6_err", bus.fpu_err, 0);
    check("t6_done", bus.fpu_done, 0);
    finish_op(5, 32'h5555_AAAA, 12'd0, 12'd0);
    ack_and_check("t6_ack");

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(0, 11);
      d = $urandom_range(0, 5);
      launch(i);
      repeat (d) tick();
      extra = ($urandom_range(0, 3) == 0) ? (12'($urandom) & ~(12'd1 << i)) : 12'd0;
      en_x  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 12'hFFE)) : 12'd0;
      finish_op(i, $urandom, extra, en_x);
      if ($urandom_range(0, 1) == 1) begin
        bus.unit_done = 12'($urandom_range(1, 12'hFFF));
        exp_err[1] = 1'b1;
        tick();
        idle_inputs();
        check("rnd_done_spurious_err", bus.fpu_err, exp_err);
        check("rnd_done_held", bus.fpu_done, 1);
      end
      ack_and_check("rnd_ack");
    end

    tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
